// File: rtl/fifo_credit_sender.sv
// fifo_credit_sender
// Credit-based transmitter feeding a remote fifo over a link that has no
// back-pressure wire. Upstream uses valid/ready; downstream receives one
// registered tx_valid pulse per beat. A credit counter, preloaded with the
// remote fifo depth, stops the sender from ever overflowing the remote fifo.
// The receiver returns one credit for every entry it pops.

module fifo_credit_sender #(
    parameter int  CREDITS = 8,
    parameter type DATA_T  = logic [7:0],
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  DATA_T            s_data,
    output logic             tx_valid,
    output DATA_T            tx_data,
    input  logic             credit_return,
    output logic [CNT_W-1:0] credits_avail,
    output logic             drained,
    output logic             err_overflow
);

    // Counter value meaning "every remote entry is free"
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] credits_q;
    logic [CNT_W-1:0] credits_d;
    logic             tx_valid_q;
    logic             tx_valid_d;
    DATA_T            tx_data_q;
    DATA_T            tx_data_d;
    logic             err_q;
    logic             err_d;
    logic             fire;

    // Ready depends only on the registered counter, so neither s_valid nor
    // credit_return can reach any output combinationally.
    assign s_ready       = (credits_q != '0);
    assign fire          = s_valid & s_ready;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign credits_avail = credits_q;
    assign drained       = (credits_q == FULL);
    assign err_overflow  = err_q;

    // Next-state: capture the payload on fire, and move the credit counter
    // by (returned - spent); a return with nothing outstanding is an error.
    always_comb begin
        credits_d  = credits_q;
        err_d      = err_q;
        tx_valid_d = fire;
        tx_data_d  = tx_data_q;

        if (fire) begin
            tx_data_d = s_data;
        end

        if (fire && !credit_return) begin
            // fire already implies credits_q >= 1, so this cannot underflow
            credits_d = credits_q - ONE;
        end else if (!fire && credit_return) begin
            if (credits_q == FULL) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + ONE;
            end
        end
    end

    // State registers; async reset discards any in-flight beat immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_q  <= FULL;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    // The counter can never hold more credits than the remote fifo has entries.
    creditBound : assert property (@(posedge clk) disable iff (reset) credits_q <= FULL);

endmodule
